// File: rtl/aes_axis_pkg.sv
// ---------------------------------------------------------------------------
// aes_axis_pkg
// Shared definitions for the AES AXI4-Stream front end:
//   - command codes carried in the first beat of every input frame
//   - the status block sent after a successful SET_KEY
//   - the error block sent for malformed frames
//   - front-end FSM state encoding
//   - swap_bytes32, the per-beat byte reversal
// ---------------------------------------------------------------------------
package aes_axis_pkg;

    localparam int AXIS_W = 32;

    localparam logic [31:0]  CMD_SET_KEY = 32'h0000_0010;
    localparam logic [31:0]  CMD_ENCRYPT = 32'h0000_0020;

    localparam logic [127:0] STATUS_OK = 128'h0;
    localparam logic [127:0] ERR_BLK   = {128{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_KEY_LOAD,
        ST_BLK,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_SEND,
        ST_DRAIN
    } state_t;

    function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_axis_frontend_if.sv
// ---------------------------------------------------------------------------
// aes_axis_frontend_if
// One AXI4-Stream channel (32-bit beats, no tkeep/tuser).
//   tdata  : beat payload
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a frame
// Modports:
//   master : drives tdata/tvalid/tlast, observes tready
//   slave  : observes tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface aes_axis_frontend_if
    import aes_axis_pkg::*;
();
    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_axis_ser.sv
// ---------------------------------------------------------------------------
// aes_axis_ser
// 128-to-32 response serializer. A load captures a 128-bit block and the
// frame-last flag; the block is then emitted as four beats, most-significant
// word first, with tlast on the fourth beat only when the flag is set.
// Outputs are registered and held stable while tready is low.
// Configuration macro: AES_AXIS_BYTE_SWAP_EN (byte-swap each output beat).
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_load        : start a new 4-beat response (only while idle)
//   i_data        : block to serialize
//   i_last        : assert tlast on the final beat
//   m_axis        : response stream (master)
//   o_done        : combinational, high on the cycle the 4th beat transfers
// ---------------------------------------------------------------------------
module aes_axis_ser
    import aes_axis_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_load,
    input  logic [127:0]         i_data,
    input  logic                 i_last,
    aes_axis_frontend_if.master  m_axis,
    output logic                 o_done
);

    logic [1:0]  r_beatCnt;
    logic        r_last;
    logic [95:0] r_rest;
    logic [31:0] r_tdata;
    logic        r_tvalid;
    logic        r_tlast;

    logic        w_fire;
    logic [31:0] w_firstWord;
    logic [31:0] w_nextWord;

    assign w_fire = r_tvalid && m_axis.tready;

`ifdef AES_AXIS_BYTE_SWAP_EN
    assign w_firstWord = swap_bytes32(i_data[127:96]);
    assign w_nextWord  = swap_bytes32(r_rest[95:64]);
`else
    assign w_firstWord = i_data[127:96];
    assign w_nextWord  = r_rest[95:64];
`endif

    // Remaining words live in r_rest and shift up one word per accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beatCnt <= 2'd0;
            r_last    <= 1'b0;
            r_rest    <= 96'h0;
            r_tdata   <= 32'h0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else if (i_load) begin
            r_beatCnt <= 2'd0;
            r_last    <= i_last;
            r_rest    <= i_data[95:0];
            r_tdata   <= w_firstWord;
            r_tvalid  <= 1'b1;
            r_tlast   <= 1'b0;
        end else if (w_fire) begin
            if (r_beatCnt == 2'd3) begin
                r_beatCnt <= 2'd0;
                r_tdata   <= 32'h0;
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
            end else begin
                r_beatCnt <= r_beatCnt + 2'd1;
                r_rest    <= {r_rest[63:0], 32'h0};
                r_tdata   <= w_nextWord;
                r_tlast   <= r_last && (r_beatCnt == 2'd2);
            end
        end
    end

    assign o_done        = w_fire && (r_beatCnt == 2'd3);
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;

endmodule

// File: rtl/aes_axis_frontend.sv
// ---------------------------------------------------------------------------
// aes_axis_frontend
// AXI4-Stream front end of the AES accelerator. Parses command frames,
// assembles 32-bit beats into 128-bit key / plaintext blocks, hands blocks
// to the core one at a time and serializes each result (or a status/error
// block) back onto the response stream.
// Configuration macro: AES_AXIS_BYTE_SWAP_EN (byte-swap each input and
// output beat; undefined means beats map straight through).
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   s_axis         : command/key/plaintext stream (slave)
//   m_axis         : response stream (master)
//   key_o          : assembled key, held until the next SET_KEY
//   key_load_o     : one-cycle pulse when key_o updates
//   blk_o          : assembled plaintext block
//   blk_valid_o    : block offered to the core
//   blk_ready_i    : core accepts the block
//   res_i          : core result
//   res_valid_i    : result available
//   res_ready_o    : front end takes the result
// ---------------------------------------------------------------------------
module aes_axis_frontend
    import aes_axis_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 128
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    aes_axis_frontend_if.slave   s_axis,
    aes_axis_frontend_if.master  m_axis,
    output logic [BLK_W-1:0]     key_o,
    output logic                 key_load_o,
    output logic [BLK_W-1:0]     blk_o,
    output logic                 blk_valid_o,
    input  logic                 blk_ready_i,
    input  logic [BLK_W-1:0]     res_i,
    input  logic                 res_valid_i,
    output logic                 res_ready_o
);

    state_t             r_state;
    state_t             w_nextState;

    logic [1:0]         r_beatCnt;
    logic               r_frameLast;
    logic               r_drainToKey;
    logic [BLK_W-1:0]   r_keyStage;
    logic [BLK_W-1:0]   r_key;
    logic               r_keyLoad;
    logic [BLK_W-1:0]   r_blk;
    logic               r_blkValid;
    logic               r_resReady;
    logic               r_sReady;

    logic [WORD_W-1:0]  w_inWord;
    logic               w_sFire;
    logic               w_blkFire;
    logic               w_resFire;
    logic               w_collecting;
    logic               w_sReadyNext;
    logic               w_keyLoadNext;
    logic               w_blkValidNext;
    logic               w_resReadyNext;
    logic               w_serLoad;
    logic [BLK_W-1:0]   w_serData;
    logic               w_serLast;
    logic               w_serDone;

`ifdef AES_AXIS_BYTE_SWAP_EN
    assign w_inWord = swap_bytes32(s_axis.tdata);
`else
    assign w_inWord = s_axis.tdata;
`endif

    assign w_sFire      = r_sReady && s_axis.tvalid;
    assign w_blkFire    = r_blkValid && blk_ready_i;
    assign w_resFire    = r_resReady && res_valid_i;
    assign w_collecting = (r_state == ST_KEY) || (r_state == ST_BLK);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Command codes are compared on the raw bus word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sFire) begin
                    if (s_axis.tlast)                    w_nextState = ST_SEND;
                    else if (s_axis.tdata == CMD_SET_KEY) w_nextState = ST_KEY;
                    else if (s_axis.tdata == CMD_ENCRYPT) w_nextState = ST_BLK;
                    else                                  w_nextState = ST_DRAIN;
                end
            end
            ST_KEY: begin
                if (w_sFire) begin
                    if (r_beatCnt == 2'd3) w_nextState = s_axis.tlast ? ST_KEY_LOAD : ST_DRAIN;
                    else if (s_axis.tlast) w_nextState = ST_SEND;
                end
            end
            ST_KEY_LOAD: w_nextState = ST_SEND;
            ST_BLK: begin
                if (w_sFire) begin
                    if (r_beatCnt == 2'd3) w_nextState = ST_ISSUE;
                    else if (s_axis.tlast) w_nextState = ST_SEND;
                end
            end
            ST_ISSUE: begin
                if (w_blkFire) w_nextState = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (w_resFire) w_nextState = ST_SEND;
            end
            ST_SEND: begin
                if (w_serDone) w_nextState = r_frameLast ? ST_IDLE : ST_BLK;
            end
            ST_DRAIN: begin
                if (w_sFire && s_axis.tlast) w_nextState = r_drainToKey ? ST_KEY_LOAD : ST_SEND;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every handshake output can be
    // registered and still line up with the state it belongs to. Entering
    // SEND from any other state loads the serializer: the core result when
    // coming from WAIT_RES, the status block from KEY_LOAD, otherwise the
    // error block (status/error always close the frame).
    always_comb begin
        w_sReadyNext   = (w_nextState == ST_IDLE) || (w_nextState == ST_KEY) ||
                         (w_nextState == ST_BLK)  || (w_nextState == ST_DRAIN);
        w_keyLoadNext  = (w_nextState == ST_KEY_LOAD);
        w_blkValidNext = (w_nextState == ST_ISSUE);
        w_resReadyNext = (w_nextState == ST_WAIT_RES);
        w_serLoad      = (w_nextState == ST_SEND) && (r_state != ST_SEND);
        w_serData      = ERR_BLK;
        w_serLast      = 1'b1;
        if (r_state == ST_WAIT_RES) begin
            w_serData = res_i;
            w_serLast = r_frameLast;
        end else if (r_state == ST_KEY_LOAD) begin
            w_serData = STATUS_OK;
        end
    end

    // Registered outputs and datapath. Key and block beats shift in from the
    // low word so beat 0 ends up in the top word after four beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beatCnt    <= 2'd0;
            r_frameLast  <= 1'b0;
            r_drainToKey <= 1'b0;
            r_keyStage   <= '0;
            r_key        <= '0;
            r_keyLoad    <= 1'b0;
            r_blk        <= '0;
            r_blkValid   <= 1'b0;
            r_resReady   <= 1'b0;
            r_sReady     <= 1'b0;
        end else begin
            r_sReady   <= w_sReadyNext;
            r_keyLoad  <= w_keyLoadNext;
            r_blkValid <= w_blkValidNext;
            r_resReady <= w_resReadyNext;

            if (w_sFire && w_collecting) begin
                if (s_axis.tlast || (r_beatCnt == 2'd3)) r_beatCnt <= 2'd0;
                else                                      r_beatCnt <= r_beatCnt + 2'd1;
            end else if (!w_collecting) begin
                r_beatCnt <= 2'd0;
            end

            if (w_sFire && (r_state == ST_KEY)) begin
                r_keyStage <= {r_keyStage[BLK_W-WORD_W-1:0], w_inWord};
            end
            if (w_sFire && (r_state == ST_BLK)) begin
                r_blk <= {r_blk[BLK_W-WORD_W-1:0], w_inWord};
            end

            // key_o only changes once a full key has arrived.
            if ((r_state == ST_KEY) && (w_nextState == ST_KEY_LOAD)) begin
                r_key <= {r_keyStage[BLK_W-WORD_W-1:0], w_inWord};
            end else if ((r_state == ST_DRAIN) && (w_nextState == ST_KEY_LOAD)) begin
                r_key <= r_keyStage;
            end

            if ((r_state == ST_KEY) && (w_nextState == ST_DRAIN)) begin
                r_drainToKey <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_drainToKey <= 1'b0;
            end

            if (w_sFire && (r_state == ST_BLK) && (r_beatCnt == 2'd3)) begin
                r_frameLast <= s_axis.tlast;
            end else if (w_serLoad && (r_state != ST_WAIT_RES)) begin
                r_frameLast <= 1'b1;
            end
        end
    end

    assign s_axis.tready = r_sReady;
    assign key_o         = r_key;
    assign key_load_o    = r_keyLoad;
    assign blk_o         = r_blk;
    assign blk_valid_o   = r_blkValid;
    assign res_ready_o   = r_resReady;

    aes_axis_ser uSer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_load  (w_serLoad),
        .i_data  (w_serData),
        .i_last  (w_serLast),
        .m_axis  (m_axis),
        .o_done  (w_serDone)
    );

endmodule

// File: tb/tb_aes_axis_frontend.sv
// ---------------------------------------------------------------------------
// tb_aes_axis_frontend
// Directed bench for aes_axis_frontend: key load, single and two-block
// encrypt, truncated block, unknown command with drain, and mid-frame reset.
// Expected values are hand-computed; the byte-swapped variants apply when
// AES_AXIS_BYTE_SWAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_aes_axis_frontend;
    import aes_axis_pkg::*;

`ifdef AES_AXIS_BYTE_SWAP_EN
    localparam logic [127:0] KEY_EXP  = 128'h54686174_73206D79_204B756E_67204675;
    localparam logic [127:0] KEY2_EXP = 128'h01000000_02000000_03000000_04000000;
    localparam logic [127:0] BLK1     = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    localparam logic [127:0] BLK2     = 128'h67452301_EFCDAB89_98BADCFE_10325476;
    localparam logic [127:0] RESP1    = 128'h5F50C329_F6201457_B3992240_3AD7021A;
    localparam logic [127:0] RESP2    = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
`else
    localparam logic [127:0] KEY_EXP  = 128'h74616854_796D2073_6E754B20_75462067;
    localparam logic [127:0] KEY2_EXP = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] BLK1     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK2     = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] RESP1    = 128'h29C3505F_571420F6_402299B3_1A02D73A;
    localparam logic [127:0] RESP2    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`endif
    localparam logic [127:0] CORE_RES1 = 128'h29C3505F_571420F6_402299B3_1A02D73A;
    localparam logic [127:0] CORE_RES2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] ALL_ONES  = {128{1'b1}};

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [127:0] keyO, blkO, resI;
    logic         keyLoadO, blkValidO, blkReadyI, resValidI, resReadyO;

    int           errors = 0;
    int           checks = 0;
    int           keyLoadPulses = 0;
    int           blkValidCycles = 0;
    logic [31:0]  rxData [8];
    logic         rxLast [8];
    int           rxCount;
    int           snap;

    aes_axis_frontend_if sIf ();
    aes_axis_frontend_if mIf ();

    always #5 aclk = ~aclk;

    aes_axis_frontend #(.WORD_W(32), .BLK_W(128)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (sIf),
        .m_axis      (mIf),
        .key_o       (keyO),
        .key_load_o  (keyLoadO),
        .blk_o       (blkO),
        .blk_valid_o (blkValidO),
        .blk_ready_i (blkReadyI),
        .res_i       (resI),
        .res_valid_i (resValidI),
        .res_ready_o (resReadyO)
    );

    // Count key_load_o and blk_valid_o cycles, sampled mid-cycle.
    always @(negedge aclk) begin
        if (keyLoadO) keyLoadPulses++;
        if (blkValidO) blkValidCycles++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one input beat and wait (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        bit done = 0;
        @(negedge aclk);
        sIf.tdata  = data;
        sIf.tvalid = 1'b1;
        sIf.tlast  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            if (sIf.tready) begin
                @(posedge aclk);
                done = 1;
            end else begin
                @(negedge aclk);
            end
        end
        checkOutput("s_handshake", done, 1);
        #1;
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
    endtask

    // Accept n response beats; toggle applies 2-low/6-high tready.
    task automatic collectResp(input int n, input bit toggle);
        rxCount = 0;
        for (int cyc = 0; cyc < 300 && rxCount < n; cyc++) begin
            @(negedge aclk);
            mIf.tready = toggle ? ((cyc % 8) >= 2) : 1'b1;
            if (mIf.tvalid && mIf.tready) begin
                rxData[rxCount] = mIf.tdata;
                rxLast[rxCount] = mIf.tlast;
                rxCount++;
            end
        end
        @(posedge aclk);
        #1 mIf.tready = 1'b0;
        checkOutput("rx_count", rxCount, n);
    endtask

    task automatic checkBeats(input string tag, input logic [127:0] exp, input logic lastOnFinal);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_beat%0d", tag, i), rxData[i], exp[127-32*i -: 32]);
            checkOutput($sformatf("%s_last%0d", tag, i), rxLast[i], (i == 3) && lastOnFinal);
        end
    endtask

    // Act as the AES core: accept the offered block, then return a result.
    task automatic coreRespond(input string tag, input logic [127:0] expBlk, input logic [127:0] res);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            if (blkValidO) seen = 1;
        end
        checkOutput({tag, "_blk_valid"}, seen, 1);
        checkOutput({tag, "_blk_o"}, blkO, expBlk);
        blkReadyI = 1'b1;
        @(negedge aclk);
        blkReadyI = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (resReadyO) seen = 1;
            else @(negedge aclk);
        end
        checkOutput({tag, "_res_ready"}, seen, 1);
        resI      = res;
        resValidI = 1'b1;
        @(posedge aclk);
        #1 resValidI = 1'b0;
        @(negedge aclk);
        checkOutput({tag, "_m_tvalid_latency"}, mIf.tvalid, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_s_tready"}, sIf.tready, 0);
        checkOutput({tag, "_m_tvalid"}, mIf.tvalid, 0);
        checkOutput({tag, "_m_tlast"}, mIf.tlast, 0);
        checkOutput({tag, "_m_tdata"}, mIf.tdata, 0);
        checkOutput({tag, "_key_o"}, keyO, 0);
        checkOutput({tag, "_key_load"}, keyLoadO, 0);
        checkOutput({tag, "_blk_o"}, blkO, 0);
        checkOutput({tag, "_blk_valid"}, blkValidO, 0);
        checkOutput({tag, "_res_ready"}, resReadyO, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        sIf.tdata  = 32'h0;
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
        mIf.tready = 1'b0;
        blkReadyI  = 1'b0;
        resValidI  = 1'b0;
        resI       = 128'h0;

        #2 checkResetState("reset");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1 checkOutput("tready_before_edge", sIf.tready, 0);
        @(negedge aclk);
        checkOutput("tready_after_edge", sIf.tready, 1);

        $display("[TB] SET_KEY frame");
        snap = keyLoadPulses;
        applyStimulus(CMD_SET_KEY, 1'b0);
        applyStimulus(32'h74616854, 1'b0);
        applyStimulus(32'h796D2073, 1'b0);
        applyStimulus(32'h6E754B20, 1'b0);
        applyStimulus(32'h75462067, 1'b1);
        @(negedge aclk);
        checkOutput("key_load_pulse", keyLoadO, 1);
        checkOutput("key_value", keyO, KEY_EXP);
        checkOutput("status_not_yet", mIf.tvalid, 0);
        @(negedge aclk);
        checkOutput("key_load_end", keyLoadO, 0);
        checkOutput("status_valid", mIf.tvalid, 1);
        collectResp(4, 1'b0);
        checkBeats("status", STATUS_OK, 1'b1);
        checkOutput("key_load_count", keyLoadPulses - snap, 1);

        $display("[TB] ENCRYPT single block");
        applyStimulus(CMD_ENCRYPT, 1'b0);
        applyStimulus(32'h00112233, 1'b0);
        applyStimulus(32'h44556677, 1'b0);
        applyStimulus(32'h8899AABB, 1'b0);
        applyStimulus(32'hCCDDEEFF, 1'b1);
        @(negedge aclk);
        checkOutput("blk_valid_latency", blkValidO, 1);
        coreRespond("enc1", BLK1, CORE_RES1);
        collectResp(4, 1'b0);
        checkBeats("enc1", RESP1, 1'b1);
        checkOutput("key_held", keyO, KEY_EXP);

        $display("[TB] ENCRYPT two blocks, throttled response");
        applyStimulus(CMD_ENCRYPT, 1'b0);
        applyStimulus(32'h00112233, 1'b0);
        applyStimulus(32'h44556677, 1'b0);
        applyStimulus(32'h8899AABB, 1'b0);
        applyStimulus(32'hCCDDEEFF, 1'b0);
        coreRespond("enc2a", BLK1, CORE_RES1);
        collectResp(4, 1'b1);
        checkBeats("enc2a", RESP1, 1'b0);
        applyStimulus(32'h01234567, 1'b0);
        applyStimulus(32'h89ABCDEF, 1'b0);
        applyStimulus(32'hFEDCBA98, 1'b0);
        applyStimulus(32'h76543210, 1'b1);
        coreRespond("enc2b", BLK2, CORE_RES2);
        collectResp(4, 1'b1);
        checkBeats("enc2b", RESP2, 1'b1);
        mIf.tready = 1'b1;
        snap = 0;
        repeat (6) begin
            @(negedge aclk);
            if (mIf.tvalid) snap++;
        end
        mIf.tready = 1'b0;
        checkOutput("enc2_no_extra_beat", snap, 0);

        $display("[TB] ENCRYPT truncated block");
        snap = blkValidCycles;
        applyStimulus(CMD_ENCRYPT, 1'b0);
        applyStimulus(32'hDEADBEEF, 1'b0);
        applyStimulus(32'hCAFEF00D, 1'b1);
        collectResp(4, 1'b0);
        checkBeats("trunc", ALL_ONES, 1'b1);
        checkOutput("trunc_no_blk_valid", blkValidCycles - snap, 0);

        $display("[TB] unknown command, then SET_KEY");
        applyStimulus(32'h0000_0099, 1'b0);
        applyStimulus(32'h11111111, 1'b0);
        applyStimulus(32'h22222222, 1'b0);
        applyStimulus(32'h33333333, 1'b1);
        collectResp(4, 1'b0);
        checkBeats("badcmd", ALL_ONES, 1'b1);
        checkOutput("badcmd_key_kept", keyO, KEY_EXP);
        snap = keyLoadPulses;
        applyStimulus(CMD_SET_KEY, 1'b0);
        applyStimulus(32'h00000001, 1'b0);
        applyStimulus(32'h00000002, 1'b0);
        applyStimulus(32'h00000003, 1'b0);
        applyStimulus(32'h00000004, 1'b1);
        collectResp(4, 1'b0);
        checkBeats("key2_status", STATUS_OK, 1'b1);
        checkOutput("key2_value", keyO, KEY2_EXP);
        checkOutput("key2_load_count", keyLoadPulses - snap, 1);

        $display("[TB] reset during third block beat");
        applyStimulus(CMD_ENCRYPT, 1'b0);
        applyStimulus(32'hAAAA0000, 1'b0);
        applyStimulus(32'hBBBB1111, 1'b0);
        @(negedge aclk);
        sIf.tdata  = 32'hCCCC2222;
        sIf.tvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1 checkResetState("midreset");
        sIf.tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("post_reset_tready", sIf.tready, 1);
        applyStimulus(CMD_ENCRYPT, 1'b0);
        applyStimulus(32'h00112233, 1'b0);
        applyStimulus(32'h44556677, 1'b0);
        applyStimulus(32'h8899AABB, 1'b0);
        applyStimulus(32'hCCDDEEFF, 1'b1);
        coreRespond("enc3", BLK1, CORE_RES1);
        collectResp(4, 1'b0);
        checkBeats("enc3", RESP1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_axis_frontend.md
# aes_axis_frontend

AXI4-Stream front end of the AES accelerator. It receives the command/data word stream from the DMA master and assembles 32-bit beats into 128-bit key and block values for the AES core. It then serializes each 128-bit core result back onto the response stream as four 32-bit beats. It sits between the DMA AXI-Stream ports and the AES round engine, and is the receiving end of the stream that the software driver and the block-design bench transmit.

## Interface
Parameters:
- WORD_W, 32, stream beat width; fixed, other values unsupported
- BLK_W, 128, AES block and key width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  32  command/key/plaintext beats
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted
- s_axis_tlast  in  1  last beat of a command frame
- m_axis_tdata  out  32  response beats
- m_axis_tvalid  out  1  response beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of the response frame
- key_o  out  128  assembled key, held until the next SET_KEY
- key_load_o  out  1  one-cycle pulse when key_o is updated
- blk_o  out  128  assembled plaintext block
- blk_valid_o  out  1  block offered to the core
- blk_ready_i  in  1  core accepts the block
- res_i  in  128  core result
- res_valid_i  in  1  result available
- res_ready_o  out  1  frontend takes the result

## Operation
- Frame format: the first beat is the command word, followed by data beats. tlast marks the final beat.
- Command codes:
  - CMD_SET_KEY = 32'h0000_0010
  - CMD_ENCRYPT = 32'h0000_0020
- Beat-to-block mapping: beat k (k = 0..3) of a group fills bits [127-32k -: 32]. Each beat is byte-swapped, so bus beat 32'h74616854 yields block bytes 54 68 61 74.
- Response beats are byte-swapped the same way, and are emitted most-significant word first.
- FSM states: IDLE, KEY, KEY_LOAD, BLK, ISSUE, WAIT_RES, SEND, DRAIN.
  - IDLE: accept the command word.
    - SET_KEY without tlast -> KEY.
    - ENCRYPT without tlast -> BLK.
    - Any other code, or tlast on the command beat -> error path (DRAIN if tlast is still pending, else directly SEND with the error block).
  - KEY: collect 4 beats.
    - tlast on beat 3 -> KEY_LOAD.
    - tlast on an earlier beat -> SEND with the error block; key_o is unchanged.
    - Beat 3 without tlast -> DRAIN, then KEY_LOAD.
  - KEY_LOAD: pulse key_load_o for one cycle, then SEND with the status block 128'h0 and tlast set.
  - BLK: collect 4 beats.
    - tlast before beat 3 -> discard the partial block and SEND the error block.
    - Beat 3 complete -> ISSUE, recording last = tlast.
  - ISSUE: blk_valid_o is high until blk_ready_i is seen, then -> WAIT_RES.
  - WAIT_RES: res_ready_o is high. On res_valid_i, latch res_i and go to SEND.
  - SEND: emit 4 beats. m_axis_tlast is asserted on beat 3 only if the block was the last of the frame (or is the status/error block).
    - After beat 3 is accepted: -> IDLE if last, else -> BLK.
  - DRAIN: accept and discard beats until tlast.
- Error block: all four beats 32'hFFFF_FFFF, with tlast on beat 3.
- s_axis_tready is high only in IDLE, KEY, BLK and DRAIN.
- Exactly one block is in flight at a time; no overlap between input collection and output serialization.

## Timing
- Reset values:
  - s_axis_tready=0
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
  - key_o=0, key_load_o=0
  - blk_o=0, blk_valid_o=0
  - res_ready_o=0
  - FSM in IDLE, beat counter 0
  - s_axis_tready rises on the first aclk edge after reset deassertion.
- All outputs are registered.
- Latency:
  - The 4th key beat handshake is followed by key_load_o high on the next cycle, then the first status beat valid on the cycle after.
  - The 4th block beat handshake is followed by blk_valid_o on the next cycle.
  - A res_valid_i && res_ready_o handshake is followed by m_axis_tvalid on the next cycle.
- The AXI rule applies: m_axis_tvalid/tdata/tlast are held stable until m_axis_tready. One beat is transferred per cycle while m_axis_tready stays high.
- blk_o is stable while blk_valid_o is high.
- Asserting aresetn low mid-frame aborts immediately: the partial block is lost, key_o is cleared, and no response is emitted.

## Configuration
- AES_AXIS_BYTE_SWAP_EN:
  - Defined: per-beat byte swap on both input and output, matching the kernel driver's little-endian word packing.
  - Undefined: beats map straight through (bus bit 31 = block byte MSB). Required for the bare-metal path.

## Structure
- Shared package aes_axis_pkg:
  - CMD_SET_KEY, CMD_ENCRYPT, the STATUS_OK block, the ERR_BLK block
  - FSM state enum
  - swap_bytes32 function
- One sub-module aes_axis_ser: 128-to-32 serializer holding the SEND beat counter and the tlast flag.

## Test plan
- SET_KEY, key beats 74616854 796D2073 6E754B20 75462067 (tlast on the last) -> key_o=5468617473206D79204B756E67204675, a single key_load_o pulse, response 4×00000000 with tlast on beat 4.
- ENCRYPT with one block (tlast), core model returning 29C3505F571420F6402299B31A02D73A -> response beats 5F50C329 F6201457 B3992240 3AD7021A, tlast on beat 4.
- ENCRYPT with two blocks, m_axis_tready toggling 2 low / 6 high -> 8 response beats, tlast only on beat 8, no beat dropped or duplicated.
- ENCRYPT with tlast on the 2nd plaintext beat -> blk_valid_o never asserted, response 4×FFFFFFFF.
- Command 32'h0000_0099 followed by 3 beats with tlast -> beats drained, response 4×FFFFFFFF, then a SET_KEY frame completes normally.
- aresetn low during the 3rd block beat -> all outputs at reset values. A following ENCRYPT frame produces a correct response.
